score_level_tracker: RTL and testbench

Downstream consumer of the line-clear result produced by the game-logic top level. Each accepted clear event (`hit` pulse plus line count 1..4) adds level-weighted points to a 6-digit BCD score, maintains a total-lines count and a level, and derives the fall-clock divisor that feeds the `ClkDiv` generating the gravity tick. The score display driver reads `score_bcd` directly.

---
 rtl/score_level_tracker.sv | 213 +++++++++++++++++++++
 tb/tb_score_level_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/score_level_tracker.sv
// Score/level tracker: BCD score accumulation, line/level counting and gravity divisor.
// Optional build macro SCORE_SATURATE_EN clamps the score at 999999 instead of wrapping.
module score_level_tracker #(
  parameter int unsigned BASE_DIV  = 50_000_000,
  parameter int unsigned DIV_STEP  = 3_000_000,
  parameter int unsigned MAX_LEVEL = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit,
  input  logic [2:0]  lines,
  output logic [23:0] score_bcd,
  output logic [9:0]  lines_total,
  output logic [3:0]  level,
  output logic [31:0] fall_div,
  output logic        busy,
  output logic        overflow,
  output logic        lost,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, LVL = 2'd2} state_t;

  localparam logic [3:0]  MAX_LVL_L  = 4'(MAX_LEVEL);
  localparam logic [31:0] BASE_DIV_L = 32'(BASE_DIV);
  localparam logic [31:0] DIV_STEP_L = 32'(DIV_STEP);

  state_t      state_q, state_d;
  logic [23:0] score_q, score_d;
  logic [9:0]  lines_total_q, lines_total_d;
  logic [3:0]  level_q, level_d;
  logic [31:0] fall_div_q, fall_div_d;
  logic [3:0]  in_level_q, in_level_d;
  logic        ovf_q, ovf_d;
  logic        lost_q, lost_d;
  logic [2:0]  cur_lines_q, cur_lines_d;
  logic [3:0]  rep_q, rep_d;
  logic        pend_v_q, pend_v_d;
  logic [2:0]  pend_lines_q, pend_lines_d;
  logic [3:0]  pend_lvl_q, pend_lvl_d;

  logic        valid_hit;
  logic [16:0] add_res;
  logic [10:0] lt_sum;
  logic [4:0]  il_sum;
  logic [4:0]  il_sub;

  function automatic logic [3:0] base_of(input logic [2:0] n);
    case (n)
      3'd1:    base_of = 4'd1;
      3'd2:    base_of = 4'd3;
      3'd3:    base_of = 4'd5;
      3'd4:    base_of = 4'd8;
      default: base_of = 4'd0;
    endcase
  endfunction

  // Adds one BCD digit into four BCD digits; bit 16 is the carry out of the top digit.
  function automatic logic [16:0] bcd_add4(input logic [15:0] a, input logic [3:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, b} : 5'd0) + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    bcd_add4 = {c, r};
  endfunction

  assign valid_hit = hit && (lines >= 3'd1) && (lines <= 3'd4);
  assign add_res   = bcd_add4(score_q[23:8], base_of(cur_lines_q));
  assign lt_sum    = {1'b0, lines_total_q} + {8'd0, cur_lines_q};
  assign il_sum    = {1'b0, in_level_q} + {2'd0, cur_lines_q};
  assign il_sub    = il_sum - 5'd10;

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    lines_total_d = lines_total_q;
    level_d       = level_q;
    fall_div_d    = fall_div_q;
    in_level_d    = in_level_q;
    ovf_d         = ovf_q;
    lost_d        = lost_q;
    cur_lines_d   = cur_lines_q;
    rep_d         = rep_q;
    pend_v_d      = pend_v_q;
    pend_lines_d  = pend_lines_q;
    pend_lvl_d    = pend_lvl_q;

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          state_d     = ADD;
          cur_lines_d = pend_lines_q;
          rep_d       = pend_lvl_q;
          pend_v_d    = valid_hit;
          if (valid_hit) begin
            pend_lines_d = lines;
            pend_lvl_d   = level_q;
          end
        end else if (valid_hit) begin
          state_d     = ADD;
          cur_lines_d = lines;
          rep_d       = level_q;
        end
      end

      ADD: begin
        if (add_res[16]) begin
          ovf_d = 1'b1;
`ifdef SCORE_SATURATE_EN
          score_d = 24'h999999;
`else
          score_d = {add_res[15:0], 8'h00};
`endif
        end else begin
          score_d = {add_res[15:0], 8'h00};
        end
        if (rep_q == 4'd0) state_d = LVL;
        else               rep_d   = rep_q - 4'd1;
        if (valid_hit) begin
          if (!pend_v_q) begin
            pend_v_d     = 1'b1;
            pend_lines_d = lines;
            pend_lvl_d   = level_q;
          end else begin
            lost_d = 1'b1;
          end
        end
      end

      LVL: begin
        lines_total_d = (lt_sum > 11'd999) ? 10'd999 : lt_sum[9:0];
        if (il_sum >= 5'd10) begin
          in_level_d = il_sub[3:0];
          if (level_q < MAX_LVL_L) begin
            level_d    = level_q + 4'd1;
            fall_div_d = fall_div_q - DIV_STEP_L;
          end
        end else begin
          in_level_d = il_sum[3:0];
        end
        // A full buffer launches now; an incoming hit takes its slot in the same edge.
        if (pend_v_q) begin
          state_d     = ADD;
          cur_lines_d = pend_lines_q;
          rep_d       = pend_lvl_q;
          pend_v_d    = valid_hit;
        end else begin
          state_d  = IDLE;
          pend_v_d = valid_hit;
        end
        if (valid_hit) begin
          pend_lines_d = lines;
          pend_lvl_d   = level_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      score_q       <= '0;
      lines_total_q <= '0;
      level_q       <= '0;
      fall_div_q    <= BASE_DIV_L;
      in_level_q    <= '0;
      ovf_q         <= 1'b0;
      lost_q        <= 1'b0;
      cur_lines_q   <= '0;
      rep_q         <= '0;
      pend_v_q      <= 1'b0;
      pend_lines_q  <= '0;
      pend_lvl_q    <= '0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lines_total_q <= lines_total_d;
      level_q       <= level_d;
      fall_div_q    <= fall_div_d;
      in_level_q    <= in_level_d;
      ovf_q         <= ovf_d;
      lost_q        <= lost_d;
      cur_lines_q   <= cur_lines_d;
      rep_q         <= rep_d;
      pend_v_q      <= pend_v_d;
      pend_lines_q  <= pend_lines_d;
      pend_lvl_q    <= pend_lvl_d;
    end
  end

  assign score_bcd   = score_q;
  assign lines_total = lines_total_q;
  assign level       = level_q;
  assign fall_div    = fall_div_q;
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;
  assign lost        = lost_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_score_level_tracker.sv
// Bench for score_level_tracker: job-timeline reference model feeding a per-cycle
// expected queue, popped and compared by an independent monitor.
module tb_score_level_tracker;

  localparam int W = 73;

  logic        clk;
  logic        rst;
  logic        hit;
  logic [2:0]  lines;
  logic [23:0] score_bcd;
  logic [9:0]  lines_total;
  logic [3:0]  level;
  logic [31:0] fall_div;
  logic        busy;
  logic        overflow;
  logic        lost;
  logic [1:0]  dbg_state;

  score_level_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .hit         (hit),
    .lines       (lines),
    .score_bcd   (score_bcd),
    .lines_total (lines_total),
    .level       (level),
    .fall_div    (fall_div),
    .busy        (busy),
    .overflow    (overflow),
    .lost        (lost),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    hit   = 1'b0;
    lines = 3'd0;
  end
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model: decimal score, job timeline with a one-deep waiting slot
  int m_score, m_lines, m_level, m_inlvl, m_div;
  bit m_ovf, m_lost;
  int cur_lines, left;
  bit pend_v;
  int pend_lines, pend_lvl;
  int base_tab[5] = '{0, 1, 3, 5, 8};

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_score = 0; m_lines = 0; m_level = 0; m_inlvl = 0; m_div = 50_000_000;
    m_ovf = 0; m_lost = 0; cur_lines = 0; left = 0; pend_v = 0;
    pend_lines = 0; pend_lvl = 0;
  endtask

  task automatic push_expected();
    logic [W-1:0] e;
    e = {to_bcd(m_score), 10'(m_lines), 4'(m_level), 32'(m_div),
         (left > 0) ? 1'b1 : 1'b0, m_ovf, m_lost};
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit r, input bit h, input int n);
    bit valid;
    int old_level;
    if (r) begin
      model_reset();
      push_expected();
      return;
    end
    valid = h && (n >= 1) && (n <= 4);
    if (left == 0) begin
      if (pend_v) begin
        cur_lines = pend_lines; left = pend_lvl + 2;
        pend_v = valid;
        if (valid) begin pend_lines = n; pend_lvl = m_level; end
      end else if (valid) begin
        cur_lines = n; left = m_level + 2;
      end
    end else if (left > 1) begin
      m_score = m_score + base_tab[cur_lines] * 100;
      if (m_score > 999999) begin
        m_ovf = 1;
`ifdef SCORE_SATURATE_EN
        m_score = 999999;
`else
        m_score = m_score - 1000000;
`endif
      end
      if (valid) begin
        if (!pend_v) begin pend_v = 1; pend_lines = n; pend_lvl = m_level; end
        else m_lost = 1;
      end
      left--;
    end else begin
      old_level = m_level;
      m_lines = (m_lines + cur_lines > 999) ? 999 : m_lines + cur_lines;
      m_inlvl = m_inlvl + cur_lines;
      if (m_inlvl >= 10) begin
        m_inlvl = m_inlvl - 10;
        if (m_level < 15) begin
          m_level++;
          m_div = m_div - 3_000_000;
        end
      end
      if (pend_v) begin
        cur_lines = pend_lines; left = pend_lvl + 2;
      end else begin
        left = 0;
      end
      pend_v = valid;
      if (valid) begin pend_lines = n; pend_lvl = old_level; end
    end
    push_expected();
  endtask

  // driver
  task automatic step(input bit r, input bit h, input int n);
    @(negedge clk);
    rst   = r;
    hit   = h;
    lines = 3'(n);
    model_step(r, h, n);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("score_bcd",   {8'd0, score_bcd},    {8'd0, e[72:49]});
        check("lines_total", {22'd0, lines_total}, {22'd0, e[48:39]});
        check("level",       {28'd0, level},       {28'd0, e[38:35]});
        check("fall_div",    fall_div,             e[34:3]);
        check("busy",        {31'd0, busy},        {31'd0, e[2]});
        check("overflow",    {31'd0, overflow},    {31'd0, e[1]});
        check("lost",        {31'd0, lost},        {31'd0, e[0]});
      end
    end
  end

  // stimulus
  initial begin
    model_reset();
    step(1, 0, 0); step(1, 0, 0);
    idle(2);
    step(0, 1, 4); idle(4);
    step(0, 1, 0); idle(1); step(0, 1, 5); idle(1); step(0, 1, 7); idle(2);

    step(1, 0, 0);
    for (int i = 0; i < 11; i++) begin step(0, 1, 1); idle(4); end
    step(0, 1, 2); idle(5);
    step(0, 1, 3); step(0, 1, 1); step(0, 1, 2); idle(10);

    // reset while a transaction is in its add phase
    step(0, 1, 3); step(1, 0, 0); idle(3);

    // continuous four-line hits push through every level and past the score limit
    for (int i = 0; i < 2000; i++) step(0, 1, 4);
    idle(20);

    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) step(1, 0, 0);
      else step(0, ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
    end
    idle(25);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
